// File: rtl/xoodyak_vector_player.sv
// Vector sequencer replaying a host-loaded {opmode, data, expected, check} table into xoodyak_build.
// Optional XOOD_VP_LOOP_EN enables continuous replay; ports: table write, run control, core drive/return, results.
module xoodyak_vector_player #(
  parameter int NUM_VEC = 64,
  parameter int OP_W    = 6,
  parameter int DATA_W  = 352,
  parameter int TEXT_W  = 192,
  parameter int HOLD_W  = 4,
  parameter int TMO_CYC = 256,
  localparam int IW     = $clog2(NUM_VEC),
  localparam int CW     = IW + 1
) (
  input  logic              eph1,
  input  logic              reset_n,
  input  logic              wr_en,
  input  logic [IW-1:0]     wr_addr,
  input  logic [OP_W-1:0]   wr_op,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [TEXT_W-1:0] wr_exp,
  input  logic              wr_chk,
  input  logic [CW-1:0]     num_vec,
  input  logic [HOLD_W-1:0] hold_cyc,
  input  logic              start,
  input  logic              loop,
  output logic [OP_W-1:0]   opmode_o,
  output logic [DATA_W-1:0] input_data_o,
  input  logic [TEXT_W-1:0] textout_i,
  input  logic              textout_valid_i,
  output logic              busy,
  output logic              done,
  output logic [CW-1:0]     pass_cnt,
  output logic [CW-1:0]     fail_cnt,
  output logic [IW-1:0]     first_fail_idx
);

  localparam int TW = $clog2(TMO_CYC + 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ISSUE = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_ADV   = 3'd3;
  localparam logic [2:0] S_END   = 3'd4;

  logic [OP_W-1:0]   op_m   [NUM_VEC];
  logic [DATA_W-1:0] data_m [NUM_VEC];
  logic [TEXT_W-1:0] exp_m  [NUM_VEC];
  logic              chk_m  [NUM_VEC];

  logic [2:0]        state_q, state_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [IW-1:0]     last_q, last_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic [HOLD_W-1:0] cnt_q, cnt_d;
  logic [TW-1:0]     tmo_q, tmo_d;
  logic              vld_q, vld_d;
  logic [TEXT_W-1:0] txt_q, txt_d;
  logic [CW-1:0]     pass_q, pass_d;
  logic [CW-1:0]     fail_q, fail_d;
  logic [IW-1:0]     ffi_q, ffi_d;
  logic              rerun;

`ifdef XOOD_VP_LOOP_EN
  logic loop_q, loop_d;
  // Sampled at start; a live deassert ends the run at the next wrap.
  assign rerun = loop_q & loop;
`else
  logic unused_loop;
  assign unused_loop = loop;
  assign rerun = 1'b0;
`endif

  // Table has no reset; writes only while idle.
  always_ff @(posedge eph1) begin
    if (wr_en && state_q == S_IDLE) begin
      op_m[wr_addr]   <= wr_op;
      data_m[wr_addr] <= wr_data;
      exp_m[wr_addr]  <= wr_exp;
      chk_m[wr_addr]  <= wr_chk;
    end
  end

  logic              got_vld;
  logic [TEXT_W-1:0] got_txt;
  logic              hit, miss;

  // A valid latched earlier wins over the live bus.
  assign got_vld = vld_q | textout_valid_i;
  assign got_txt = vld_q ? txt_q : textout_i;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    last_d  = last_q;
    hold_d  = hold_q;
    cnt_d   = cnt_q;
    tmo_d   = tmo_q;
    vld_d   = vld_q;
    txt_d   = txt_q;
    pass_d  = pass_q;
    fail_d  = fail_q;
    ffi_d   = ffi_q;
`ifdef XOOD_VP_LOOP_EN
    loop_d  = loop_q;
`endif
    hit     = 1'b0;
    miss    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_ISSUE;
          idx_d   = '0;
          cnt_d   = '0;
          tmo_d   = '0;
          vld_d   = 1'b0;
          pass_d  = '0;
          fail_d  = '0;
          ffi_d   = '0;
          hold_d  = (hold_cyc == '0) ? HOLD_W'(1) : hold_cyc;
          if (num_vec == '0)
            last_d = '0;
          else if (num_vec > CW'(NUM_VEC))
            last_d = IW'(NUM_VEC - 1);
          else
            last_d = IW'(num_vec - 1'b1);
`ifdef XOOD_VP_LOOP_EN
          loop_d  = loop;
`endif
        end
      end
      S_ISSUE: begin
        if (textout_valid_i && !vld_q) begin
          vld_d = 1'b1;
          txt_d = textout_i;
        end
        if (cnt_q == HOLD_W'(hold_q - 1'b1)) begin
          cnt_d   = '0;
          state_d = chk_m[idx_q] ? S_WAIT : S_ADV;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_WAIT: begin
        if (got_vld) begin
          hit     = (got_txt == exp_m[idx_q]);
          miss    = ~hit;
          state_d = S_ADV;
        end else if (tmo_q == TW'(TMO_CYC - 1)) begin
          miss    = 1'b1;
          state_d = S_ADV;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      S_ADV: begin
        vld_d = 1'b0;
        tmo_d = '0;
        if (idx_q == last_q) begin
          idx_d   = '0;
          state_d = rerun ? S_ISSUE : S_END;
        end else begin
          idx_d   = idx_q + 1'b1;
          state_d = S_ISSUE;
        end
      end
      S_END:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (hit && pass_q != '1)
      pass_d = pass_q + 1'b1;
    if (miss) begin
      if (fail_q == '0)
        ffi_d = idx_q;
      if (fail_q != '1)
        fail_d = fail_q + 1'b1;
    end
  end

  always_ff @(posedge eph1 or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      last_q  <= '0;
      hold_q  <= '0;
      cnt_q   <= '0;
      tmo_q   <= '0;
      vld_q   <= 1'b0;
      txt_q   <= '0;
      pass_q  <= '0;
      fail_q  <= '0;
      ffi_q   <= '0;
`ifdef XOOD_VP_LOOP_EN
      loop_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      last_q  <= last_d;
      hold_q  <= hold_d;
      cnt_q   <= cnt_d;
      tmo_q   <= tmo_d;
      vld_q   <= vld_d;
      txt_q   <= txt_d;
      pass_q  <= pass_d;
      fail_q  <= fail_d;
      ffi_q   <= ffi_d;
`ifdef XOOD_VP_LOOP_EN
      loop_q  <= loop_d;
`endif
    end
  end

  assign busy           = (state_q != S_IDLE);
  assign done           = (state_q == S_END);
  assign opmode_o       = busy ? op_m[idx_q] : '0;
  assign input_data_o   = busy ? data_m[idx_q] : '0;
  assign pass_cnt       = pass_q;
  assign fail_cnt       = fail_q;
  assign first_fail_idx = ffi_q;

endmodule

// File: tb/tb_xoodyak_vector_player.sv
// Randomized bench for xoodyak_vector_player.
// Timeline and counts come from a per-entry model of the replay rules.
module tb_xoodyak_vector_player;

  localparam int NV  = 64;
  localparam int TMO = 256;
  localparam int SAT = 127;

  logic         eph1 = 0;
  logic         reset_n;
  logic         wr_en;
  logic [5:0]   wr_addr;
  logic [5:0]   wr_op;
  logic [351:0] wr_data;
  logic [191:0] wr_exp;
  logic         wr_chk;
  logic [6:0]   num_vec;
  logic [3:0]   hold_cyc;
  logic         start;
  logic         loop;
  logic [5:0]   opmode_o;
  logic [351:0] input_data_o;
  logic [191:0] textout_i;
  logic         textout_valid_i;
  logic         busy;
  logic         done;
  logic [6:0]   pass_cnt;
  logic [6:0]   fail_cnt;
  logic [5:0]   first_fail_idx;

  xoodyak_vector_player dut (
    .eph1(eph1),
    .reset_n(reset_n),
    .wr_en(wr_en),
    .wr_addr(wr_addr),
    .wr_op(wr_op),
    .wr_data(wr_data),
    .wr_exp(wr_exp),
    .wr_chk(wr_chk),
    .num_vec(num_vec),
    .hold_cyc(hold_cyc),
    .start(start),
    .loop(loop),
    .opmode_o(opmode_o),
    .input_data_o(input_data_o),
    .textout_i(textout_i),
    .textout_valid_i(textout_valid_i),
    .busy(busy),
    .done(done),
    .pass_cnt(pass_cnt),
    .fail_cnt(fail_cnt),
    .first_fail_idx(first_fail_idx)
  );

  always #5 eph1 = ~eph1;

  logic [5:0]   m_op   [NV];
  logic [351:0] m_data [NV];
  logic [191:0] m_exp  [NV];
  bit           m_chk  [NV];
  int           lat    [NV];
  bit           flip   [NV];

  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [383:0] got,
                       input logic [383:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [351:0] rnd352();
    logic [351:0] r;
    for (int i = 0; i < 11; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  function automatic logic [191:0] rnd192();
    logic [191:0] r;
    for (int i = 0; i < 6; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  function automatic int sat(input int v);
    return (v > SAT) ? SAT : v;
  endfunction

  task automatic stage(input int a, input logic [5:0] op,
                       input logic [351:0] d, input logic [191:0] e,
                       input bit c);
    wr_addr = 6'(a);
    wr_op   = op;
    wr_data = d;
    wr_exp  = e;
    wr_chk  = c;
    m_op[a]   = op;
    m_data[a] = d;
    m_exp[a]  = e;
    m_chk[a]  = c;
  endtask

  task automatic load(input int a, input logic [5:0] op,
                      input logic [351:0] d, input logic [191:0] e,
                      input bit c);
    stage(a, op, d, e, c);
    wr_en = 1;
    @(posedge eph1); #1;
    wr_en = 0;
  endtask

  task automatic load_rand(input int n, input int tmo_odds);
    for (int i = 0; i < n; i++) begin
      load(i, 6'($urandom), rnd352(), rnd192(), 1'($urandom));
      lat[i]  = ($urandom_range(0, tmo_odds) == 0) ? -1
                : int'($urandom_range(0, 20));
      flip[i] = ($urandom_range(0, 3) == 0);
    end
  endtask

  task automatic drive(input bit v, input int e);
    textout_valid_i = v;
    textout_i = v ? (m_exp[e] ^ 192'(flip[e])) : rnd192();
  endtask

  task automatic run(input int nv, input int hold, input bit lp,
                     input int npass, input bit wr_st);
    int env, eh, passes, pa, fa, ff;
    bit v, ok;
    env = (nv == 0) ? 1 : ((nv > NV) ? NV : nv);
    eh  = (hold == 0) ? 1 : hold;
    passes = 1;
`ifdef XOOD_VP_LOOP_EN
    if (lp) passes = npass;
`endif
    pa = 0; fa = 0; ff = 0;
    num_vec  = 7'(nv);
    hold_cyc = 4'(hold);
    loop     = lp;
    start    = 1;
    wr_en    = wr_st;
    @(posedge eph1); #1;
    start    = 0;
    wr_en    = 0;
    num_vec  = 7'($urandom);
    hold_cyc = 4'($urandom);
    for (int p = 0; p < passes; p++) begin
      if (passes > 1 && p == passes - 1) loop = 0;
      for (int e = 0; e < env; e++) begin
        for (int c = 0; c < eh; c++) begin
          drive(lat[e] == c, e);
          if (c == 0) begin
            check("busy", 384'(busy), 384'(1));
            check("nodone", 384'(done), 384'(0));
            check("pass_run", 384'(pass_cnt), 384'(pa));
            check("fail_run", 384'(fail_cnt), 384'(fa));
          end
          check("opmode", 384'(opmode_o), 384'(m_op[e]));
          if (c == eh - 1)
            check("data", 384'(input_data_o), 384'(m_data[e]));
          if (p == 0 && e == 0 && c == 0) begin
            start   = 1;
            wr_en   = 1;
            wr_addr = 6'($urandom);
            wr_op   = 6'($urandom);
          end
          @(posedge eph1); #1;
          start = 0;
          wr_en = 0;
        end
        if (m_chk[e]) begin
          ok = 0;
          if (lat[e] >= 0 && lat[e] < eh) begin
            drive(0, e);
            check("hold", 384'(opmode_o), 384'(m_op[e]));
            @(posedge eph1); #1;
            ok = 1;
          end else begin
            for (int w = 0; w < TMO && !ok; w++) begin
              v = (lat[e] >= 0 && w == lat[e] - eh);
              drive(v, e);
              if (w == 0) check("hold", 384'(opmode_o), 384'(m_op[e]));
              @(posedge eph1); #1;
              ok = v;
            end
          end
          if (ok && !flip[e]) pa = sat(pa + 1);
          else begin
            if (fa == 0) ff = e;
            fa = sat(fa + 1);
          end
        end
        drive(0, e);
        @(posedge eph1); #1;
      end
    end
    textout_valid_i = 0;
    check("done", 384'(done), 384'(1));
    check("busy_end", 384'(busy), 384'(1));
    check("pass_cnt", 384'(pass_cnt), 384'(pa));
    check("fail_cnt", 384'(fail_cnt), 384'(fa));
    if (fa != 0) check("first_fail", 384'(first_fail_idx), 384'(ff));
    @(posedge eph1); #1;
    check("idle_busy", 384'(busy), 384'(0));
    check("idle_done", 384'(done), 384'(0));
    check("idle_op", 384'(opmode_o), 384'(0));
    check("idle_data", 384'(input_data_o), 384'(0));
  endtask

  initial begin
    reset_n = 0; wr_en = 0; wr_addr = 0; wr_op = 0; wr_data = 0;
    wr_exp = 0; wr_chk = 0; num_vec = 0; hold_cyc = 0; start = 0;
    loop = 0; textout_i = 0; textout_valid_i = 0;
    repeat (3) @(posedge eph1);
    #1;
    check("rst_busy", 384'(busy), 384'(0));
    check("rst_done", 384'(done), 384'(0));
    check("rst_op", 384'(opmode_o), 384'(0));
    check("rst_data", 384'(input_data_o), 384'(0));
    check("rst_pass", 384'(pass_cnt), 384'(0));
    check("rst_fail", 384'(fail_cnt), 384'(0));
    check("rst_ffi", 384'(first_fail_idx), 384'(0));
    reset_n = 1;
    @(posedge eph1); #1;

    // Key, nonce, encrypt; last entry written together with start.
    load(0, 6'h0, rnd352(), rnd192(), 0);
    load(1, 6'h1, rnd352(), rnd192(), 0);
    stage(2, 6'h4, rnd352(),
          192'hbb4416e8d6ce6ef456e2be6c08ce8eccaf42fd7c33b3de1e, 1);
    for (int i = 0; i < 3; i++) begin
      lat[i] = $urandom_range(0, 7);
      flip[i] = 0;
    end
    run(3, 4, 0, 1, 1);

    flip[2] = 1;
    run(3, 4, 0, 1, 0);

    flip[2] = 0;
    lat[2] = -1;
    run(3, 4, 0, 1, 0);

    lat[0] = 0;
    run(0, 0, 0, 1, 0);

    // Reset in the second ISSUE cycle of entry 1.
    for (int i = 0; i < 3; i++) lat[i] = 1;
    num_vec = 3; hold_cyc = 4; start = 1;
    @(posedge eph1); #1;
    start = 0;
    repeat (6) @(posedge eph1);
    #1;
    check("pre_rst_op", 384'(opmode_o), 384'(m_op[1]));
    reset_n = 0;
    #1;
    check("mid_rst_busy", 384'(busy), 384'(0));
    check("mid_rst_op", 384'(opmode_o), 384'(0));
    check("mid_rst_data", 384'(input_data_o), 384'(0));
    check("mid_rst_fail", 384'(fail_cnt), 384'(0));
    @(posedge eph1); #1;
    reset_n = 1;
    @(posedge eph1); #1;
    run(3, 4, 0, 1, 0);

    repeat (6) begin
      load_rand(16, 15);
      run($urandom_range(0, 16), $urandom_range(0, 15), 0, 1, 0);
    end

    load_rand(NV, 40);
    run(100, 1, 0, 1, 0);

    load_rand(2, 1000);
    for (int i = 0; i < 2; i++) begin
      m_chk[i] = 1;
      flip[i] = 0;
    end
    load(0, m_op[0], m_data[0], m_exp[0], 1);
    load(1, m_op[1], m_data[1], m_exp[1], 1);
    run(2, 2, 1, 3, 0);

`ifdef XOOD_VP_LOOP_EN
    load_rand(NV, 100000);
    for (int i = 0; i < NV; i++) begin
      load(i, m_op[i], m_data[i], m_exp[i], 1);
      flip[i] = 0;
      lat[i] = $urandom_range(0, 3);
    end
    run(64, 1, 1, 2, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
